// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the DMEM arbiter. Holds the
//               access-sequencing state encoding, the full byte-enable
//               constant and the requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   // Access sequencing states. The encoding is fixed so that state values
   // seen in waveforms match the documented numbering.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // All four byte lanes enabled: a plain word write, no read-modify-write.
   localparam logic [3:0] c_BE_FULL = 4'hF;

   // Requester identifiers. req0 is the CPU load/store unit, req1 is the
   // DMA/loader/debug port.
   localparam logic c_REQ0 = 1'b0;
   localparam logic c_REQ1 = 1'b1;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter (purely combinational).
//               The only valid requester wins. When both are valid, the
//               requester that did not win the previous contest wins.
// Ports       : i_valid0/i_valid1 - request valid from requester 0/1
//               i_rr_last         - id of the most recent winner
//               o_grant0/o_grant1 - one-hot grant (both 0 if nothing valid)
//               o_winner          - id of the winning requester
//               o_any             - at least one requester valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_rr_last,
   output logic o_grant0,
   output logic o_grant1,
   output logic o_winner,
   output logic o_any
);

   logic w_winner;

   always_comb begin
      w_winner = c_REQ0;
      if (i_valid0 && i_valid1) begin
         // Contest: hand the grant to whoever did not win last time.
         w_winner = ~i_rr_last;
      end else if (i_valid1) begin
         w_winner = c_REQ1;
      end
   end

   assign o_winner = w_winner;
   assign o_any    = i_valid0 | i_valid1;
   assign o_grant0 = i_valid0 & (w_winner == c_REQ0);
   assign o_grant1 = i_valid1 & (w_winner == c_REQ1);

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port, word-addressed data memory between
//               two requesters (req0: CPU LSU, req1: DMA/loader/debug).
//               Round-robin arbitration with valid/ready handshakes, one
//               access in flight, sequenced as read, full-word write, or
//               byte-masked read-modify-write, followed by a one-cycle
//               response pulse to the issuing requester.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               reqN_valid/ready      - request handshake (N = 0, 1)
//               reqN_we/addr/wdata/be - request payload
//               rspN_valid/rdata      - completion pulse and read data
//               mem_we/addr/wd        - DMEM write enable, address, data
//               mem_rd                - DMEM combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_W-1:0]     req0_addr,
   input  logic [DATA_W-1:0]     req0_wdata,
   input  logic [DATA_W/8-1:0]   req0_be,
   output logic                  rsp0_valid,
   output logic [DATA_W-1:0]     rsp0_rdata,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_W-1:0]     req1_addr,
   input  logic [DATA_W-1:0]     req1_wdata,
   input  logic [DATA_W/8-1:0]   req1_be,
   output logic                  rsp1_valid,
   output logic [DATA_W-1:0]     rsp1_rdata,

   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   localparam int c_BE_W = DATA_W / 8;

   // Replace the enabled byte lanes of the old memory word with the new
   // write data; disabled lanes keep their current memory contents.
   function automatic logic [DATA_W-1:0] f_merge(
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] old,
      input logic [c_BE_W-1:0] be
   );
      logic [DATA_W-1:0] res;
      res = old;
      for (int i = 0; i < c_BE_W; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // State and latched request
   // ---------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rr_last;
   logic                r_id;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_BE_W-1:0]   r_be;
   logic [DATA_W-1:0]   r_rdata;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic                w_grant0;
   logic                w_grant1;
   logic                w_winner;
   logic                w_any;
   logic                w_hs;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [c_BE_W-1:0]   w_sel_be;
   logic [DATA_W-1:0]   w_rsp_data;

   rr_arb2 u_rr_arb2 (
      .i_valid0  (req0_valid),
      .i_valid1  (req1_valid),
      .i_rr_last (r_rr_last),
      .o_grant0  (w_grant0),
      .o_grant1  (w_grant1),
      .o_winner  (w_winner),
      .o_any     (w_any)
   );

   // A handshake only happens in IDLE and never while reset is asserted,
   // so a request presented during reset is not silently consumed.
   assign w_hs = rst_n && (r_state == ST_IDLE) && w_any;

   assign w_sel_we    = (w_winner == c_REQ1) ? req1_we    : req0_we;
   assign w_sel_addr  = (w_winner == c_REQ1) ? req1_addr  : req0_addr;
   assign w_sel_wdata = (w_winner == c_REQ1) ? req1_wdata : req0_wdata;
   assign w_sel_be    = (w_winner == c_REQ1) ? req1_be    : req0_be;

   // Writes complete with zero read data.
   assign w_rsp_data = r_we ? '0 : r_rdata;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Request latch and data path registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_last <= c_REQ1;   // req0 wins the first contest
         r_id      <= c_REQ0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_rdata   <= '0;
      end else begin
         if (w_hs) begin
            r_rr_last <= w_winner;
            r_id      <= w_winner;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_be      <= w_sel_be;
         end
         if (r_state == ST_READ) begin
            r_rdata <= mem_rd;
         end
         // The merged word overwrites the latched write data so that
         // WRITE drives the same register for full and masked writes.
         if (r_state == ST_MERGE) begin
            r_wdata <= f_merge(r_wdata, mem_rd, r_be);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp0_valid  = 1'b0;
      rsp1_valid  = 1'b0;
      rsp0_rdata  = '0;
      rsp1_rdata  = '0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wd      = '0;

      case (r_state)
         ST_IDLE: begin
            req0_ready = rst_n & w_grant0;
            req1_ready = rst_n & w_grant1;
            if (w_any) begin
               if (!w_sel_we) begin
                  w_state_nxt = ST_READ;
               end else if (w_sel_be == c_BE_FULL) begin
                  w_state_nxt = ST_WRITE;
               end else if (w_sel_be == '0) begin
                  // Nothing to write: acknowledge without touching memory.
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_MERGE;
               end
            end
         end
         ST_READ: begin
            mem_addr    = r_addr;
            w_state_nxt = ST_RESP;
         end
         ST_MERGE: begin
            mem_addr    = r_addr;
            w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            // Suppressed under reset so an aborted access never lands.
            mem_we      = rst_n;
            mem_addr    = r_addr;
            mem_wd      = r_wdata;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (r_id == c_REQ1) begin
               rsp1_valid = rst_n;
               rsp1_rdata = rst_n ? w_rsp_data : '0;
            end else begin
               rsp0_valid = rst_n;
               rsp0_rdata = rst_n ? w_rsp_data : '0;
            end
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A per-cycle vector
//               table covers reset, reads, full/masked/empty writes; hand
//               sequences cover round-robin fairness and reset in MERGE.
//               A small word memory model stands in for the DMEM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic [3:0]  req0_be;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic [3:0]  req1_be;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_be    (req0_be),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_be    (req1_be),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // DMEM model: 64 words, combinational read, synchronous write.
   logic [31:0] mem [0:63];
   logic        mem_init;
   assign mem_rd = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
         mem[4] <= 32'hDEADBEEF;
      end else if (mem_we) begin
         mem[mem_addr[7:2]] <= mem_wd;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // One row = one clock cycle: inputs applied, outputs expected that cycle.
   // ctl = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we}
   typedef struct {
      logic        rst_n;
      logic        v0;
      logic        v1;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [4:0]  ctl;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic        chk_wd;
   } vec_t;

   vec_t vecs [18];

   logic [4:0] ctl_now;
   assign ctl_now = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we};

   int     gr_q [$];
   int     n_rsp0, n_rsp1;

   initial begin
      // reset, two idle cycles
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h0,32'h0,1'b1};
      // req0 read 0x10: ready at T, READ at T+1, rsp at T+2
      vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h10,32'h0,4'h0, 5'b10000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h10,32'h0,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00100,32'hDEADBEEF,32'h0,32'h0,32'h0,1'b1};
      // req1 full write 0x20
      vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,32'h20,32'h12345678,4'hF, 5'b01000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00001,32'h0,32'h0,32'h20,32'h12345678,1'b1};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00010,32'h0,32'h0,32'h0,32'h0,1'b1};
      // req1 read back 0x20
      vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,32'h20,32'h0,4'h0, 5'b01000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h20,32'h0,1'b0};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00010,32'h0,32'h12345678,32'h0,32'h0,1'b1};
      // req0 masked write be=0101 over 0x12345678 -> 0x12BB56DD, rsp at T+3
      vecs[11] = '{1'b1,1'b1,1'b0,1'b1,32'h20,32'hAABBCCDD,4'h5, 5'b10000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h20,32'h0,1'b0};
      vecs[13] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00001,32'h0,32'h0,32'h20,32'h12BB56DD,1'b1};
      vecs[14] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00100,32'h0,32'h0,32'h0,32'h0,1'b1};
      // req1 write with be=0 to 0x10: rsp at T+1, no memory access
      vecs[15] = '{1'b1,1'b0,1'b1,1'b1,32'h10,32'hFFFFFFFF,4'h0, 5'b01000,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[16] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00010,32'h0,32'h0,32'h0,32'h0,1'b1};
      vecs[17] = '{1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 5'b00000,32'h0,32'h0,32'h0,32'h0,1'b1};

      rst_n = 1'b0; mem_init = 1'b1;
      req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_be = 0;
      req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_be = 0;
      next_cyc();
      mem_init = 1'b0;

      // ---------------- table-driven section ----------------
      for (int i = 0; i < 18; i++) begin
         next_cyc();
         rst_n      = vecs[i].rst_n;
         req0_valid = vecs[i].v0;
         req1_valid = vecs[i].v1;
         req0_we    = vecs[i].we;   req1_we    = vecs[i].we;
         req0_addr  = vecs[i].addr; req1_addr  = vecs[i].addr;
         req0_wdata = vecs[i].wd;   req1_wdata = vecs[i].wd;
         req0_be    = vecs[i].be;   req1_be    = vecs[i].be;
         #2;
         chk($sformatf("row%0d ctl", i), {27'h0, ctl_now}, {27'h0, vecs[i].ctl});
         chk($sformatf("row%0d rsp0_rdata", i), rsp0_rdata, vecs[i].rd0);
         chk($sformatf("row%0d rsp1_rdata", i), rsp1_rdata, vecs[i].rd1);
         chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].maddr);
         if (vecs[i].chk_wd) chk($sformatf("row%0d mem_wd", i), mem_wd, vecs[i].mwd);
      end
      chk("mem[0x20] after masked write", mem[8], 32'h12BB56DD);
      chk("mem[0x10] after be=0 write", mem[4], 32'hDEADBEEF);

      // ---------------- round-robin with both valid continuously ----------
      next_cyc();
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0;
      next_cyc();
      rst_n = 1'b1;
      req0_valid = 1; req0_we = 0; req0_addr = 32'h10; req0_be = 4'h0;
      req1_valid = 1; req1_we = 0; req1_addr = 32'h20; req1_be = 4'h0;
      n_rsp0 = 0; n_rsp1 = 0;
      for (int c = 0; c < 12; c++) begin
         #2;
         chk($sformatf("rr c%0d both ready", c), {31'h0, req0_ready & req1_ready}, 32'h0);
         if (req0_ready) gr_q.push_back(0);
         if (req1_ready) gr_q.push_back(1);
         if (rsp0_valid) begin
            n_rsp0++;
            chk($sformatf("rr c%0d rsp0_rdata", c), rsp0_rdata, 32'hDEADBEEF);
            chk($sformatf("rr c%0d rsp1 idle", c), {rsp1_valid, rsp1_rdata[30:0]}, 32'h0);
         end
         if (rsp1_valid) begin
            n_rsp1++;
            chk($sformatf("rr c%0d rsp1_rdata", c), rsp1_rdata, 32'h12BB56DD);
            chk($sformatf("rr c%0d rsp0 idle", c), {rsp0_valid, rsp0_rdata[30:0]}, 32'h0);
         end
         next_cyc();
      end
      req0_valid = 0; req1_valid = 0;
      chk("rr grant count", gr_q.size(), 4);
      for (int g = 0; g < 4; g++) begin
         if (g < gr_q.size()) chk($sformatf("rr grant%0d id", g), gr_q[g], g % 2);
      end
      chk("rr rsp0 count", n_rsp0, 2);
      chk("rr rsp1 count", n_rsp1, 2);

      // ---------------- reset asserted in MERGE ----------------
      req0_valid = 1; req0_we = 1; req0_addr = 32'h10; req0_wdata = 32'h0; req0_be = 4'b0011;
      #2;
      chk("rst-merge handshake ready0", {31'h0, req0_ready}, 32'h1);
      next_cyc();
      req0_valid = 0;
      rst_n = 1'b0;
      #2;
      chk("rst-merge mem_we in MERGE", {31'h0, mem_we}, 32'h0);
      next_cyc();
      rst_n = 1'b1;
      #2;
      chk("rst-merge ctl after reset", {27'h0, ctl_now}, 32'h0);
      chk("rst-merge mem_addr after reset", mem_addr, 32'h0);
      chk("rst-merge mem_wd after reset", mem_wd, 32'h0);
      chk("rst-merge rdata after reset", rsp0_rdata | rsp1_rdata, 32'h0);
      next_cyc();
      #2;
      chk("rst-merge ctl next cycle", {27'h0, ctl_now}, 32'h0);
      next_cyc();
      chk("rst-merge memory unchanged", mem[4], 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dmem_arbiter
`default_nettype wire
